// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared instruction-cache constants, refill state encoding and address helpers
package icache_pkg;

  localparam int ADDR_W     = 16;
  localparam int WORD_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = WORD_W * LINE_WORDS;

  // Line-address slicing shared with the lookup side of the cache
  localparam int TAG_HI  = 15;
  localparam int TAG_LO  = 6;
  localparam int SET_HI  = 5;
  localparam int SET_LO  = 3;
  localparam int WORD_HI = 2;
  localparam int WORD_LO = 1;

  localparam int BASE_W = ADDR_W - SET_LO;
  localparam int IDX_W  = WORD_HI - WORD_LO + 1;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_REQ  = 2'd1,
    RS_DONE = 2'd2
  } refill_state_e;

  function automatic logic [BASE_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:SET_LO];
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [BASE_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return {base, idx, 1'b0};
  endfunction

endpackage

// File: rtl/icache_refill_if.sv
// rtl/icache_refill_if.sv - fetch-miss, memory-read and cache-write signals of the refill engine
interface icache_refill_if;
  import icache_pkg::*;

  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              busy;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;
  logic              line_valid;
  logic [ADDR_W-1:0] line_addr;
  logic [LINE_W-1:0] line_data;

  modport master (
    output miss_req, miss_addr, mem_ack, mem_rdata,
    input  busy, mem_rd, mem_addr, line_valid, line_addr, line_data
  );

  modport slave (
    input  miss_req, miss_addr, mem_ack, mem_rdata,
    output busy, mem_rd, mem_addr, line_valid, line_addr, line_data
  );

endinterface

// File: rtl/icache_line_buf.sv
// rtl/icache_line_buf.sv - four word slots written by index, read out as one concatenated line
module icache_line_buf
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [LINE_W-1:0] line_o
);

  logic [WORD_W-1:0] slot_q [LINE_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        slot_q[i] <= '0;
      end
    end else if (we_i) begin
      slot_q[idx_i] <= wdata_i;
    end
  end

  for (genvar k = 0; k < LINE_WORDS; k++) begin : g_line
    assign line_o[k*WORD_W +: WORD_W] = slot_q[k];
  end

endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - miss-side line refill engine; ICACHE_REFILL_CWF_EN selects critical-word-first order
module icache_refill
  import icache_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  icache_refill_if.slave  bus
);

  refill_state_e     state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              line_valid_q, line_valid_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;

  logic [IDX_W-1:0]  start_idx;
  logic [IDX_W-1:0]  idx_inc;
  logic              word_ack;
  logic              buf_we;
  logic              unused_addr_bits;

`ifdef ICACHE_REFILL_CWF_EN
  assign start_idx = bus.miss_addr[WORD_HI:WORD_LO];
`else
  assign start_idx = '0;
`endif

  assign unused_addr_bits = ^bus.miss_addr[SET_LO-1:0];

  assign idx_inc  = idx_q + 2'd1;
  assign word_ack = (state_q == RS_REQ) && mem_rd_q && bus.mem_ack;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    mem_rd_d     = mem_rd_q;
    mem_addr_d   = mem_addr_q;
    line_valid_d = 1'b0;
    line_addr_d  = line_addr_q;
    buf_we       = 1'b0;

    unique case (state_q)
      RS_IDLE: begin
        if (bus.miss_req) begin
          state_d     = RS_REQ;
          base_d      = line_base(bus.miss_addr);
          idx_d       = start_idx;
          cnt_d       = '0;
          mem_rd_d    = 1'b1;
          mem_addr_d  = word_addr(line_base(bus.miss_addr), start_idx);
          line_addr_d = {line_base(bus.miss_addr), {SET_LO{1'b0}}};
        end
      end

      RS_REQ: begin
        // Slot placement follows idx, so wrapped fetch orders still land in line order
        if (word_ack) begin
          buf_we     = 1'b1;
          idx_d      = idx_inc;
          cnt_d      = cnt_q + 2'd1;
          mem_addr_d = word_addr(base_q, idx_inc);
          if (cnt_q == 2'(LINE_WORDS - 1)) begin
            state_d      = RS_DONE;
            mem_rd_d     = 1'b0;
            line_valid_d = 1'b1;
          end
        end
      end

      RS_DONE: begin
        state_d = RS_IDLE;
      end

      default: begin
        state_d  = RS_IDLE;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RS_IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      line_valid_q <= 1'b0;
      line_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      line_valid_q <= line_valid_d;
      line_addr_q  <= line_addr_d;
    end
  end

  icache_line_buf u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (buf_we),
    .idx_i   (idx_q),
    .wdata_i (bus.mem_rdata),
    .line_o  (bus.line_data)
  );

  assign bus.busy       = (state_q != RS_IDLE);
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.line_valid = line_valid_q;
  assign bus.line_addr  = line_addr_q;

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed table-driven bench for icache_refill
module tb_icache_refill;

  logic clk = 1'b0;
  logic rst = 1'b1;

  icache_refill_if bus ();

  icache_refill dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      miss_addr;
    int               waits;
    logic [3:0][15:0] rdata;
    logic [3:0][15:0] exp_addr;
    logic [15:0]      exp_line_addr;
    logic [63:0]      exp_data;
  } vec_t;

  vec_t vecs [4];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_miss(input logic [15:0] addr, input bit hold, input logic [15:0] next_addr);
    @(negedge clk);
    bus.miss_req  = 1'b1;
    bus.miss_addr = addr;
    @(posedge clk);
    #1;
    if (hold) bus.miss_addr = next_addr;
    else      bus.miss_req  = 1'b0;
  endtask

  task automatic serve(input int waits, input logic [3:0][15:0] rdata,
                       input logic [3:0][15:0] exp_addr,
                       input logic [15:0] exp_la, input logic [63:0] exp_data);
    int pulses = 0;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < waits; k++) begin
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("wait_mem_rd", 64'(bus.mem_rd), 64'd1);
        check("wait_mem_addr", 64'(bus.mem_addr), 64'(exp_addr[w]));
        if (bus.line_valid) pulses++;
        @(posedge clk);
      end
      @(negedge clk);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdata[w];
      check("word_mem_rd", 64'(bus.mem_rd), 64'd1);
      check("word_mem_addr", 64'(bus.mem_addr), 64'(exp_addr[w]));
      check("word_busy", 64'(bus.busy), 64'd1);
      if (bus.line_valid) pulses++;
      @(posedge clk);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("done_line_valid", 64'(bus.line_valid), 64'd1);
    check("done_line_addr", 64'(bus.line_addr), 64'(exp_la));
    check("done_line_data", bus.line_data, exp_data);
    check("done_mem_rd", 64'(bus.mem_rd), 64'd0);
    check("done_busy", 64'(bus.busy), 64'd1);
    if (bus.line_valid) pulses++;
    @(posedge clk);
    @(negedge clk);
    check("idle_line_valid", 64'(bus.line_valid), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_line_data_hold", bus.line_data, exp_data);
    check("strobe_count", 64'(pulses), 64'd1);
  endtask

  initial begin
`ifdef ICACHE_REFILL_CWF_EN
    vecs[0] = '{16'h1234, 0, {16'hA3A3, 16'hA2A2, 16'hA1A1, 16'hA0A0},
                {16'h1232, 16'h1230, 16'h1236, 16'h1234}, 16'h1230, 64'hA1A1_A0A0_A3A3_A2A2};
    vecs[1] = '{16'h0044, 0, {16'h0004, 16'h0003, 16'h0002, 16'h0001},
                {16'h0042, 16'h0040, 16'h0046, 16'h0044}, 16'h0040, 64'h0002_0001_0004_0003};
    vecs[2] = '{16'h0ABC, 3, {16'h4004, 16'h3003, 16'h2002, 16'h1001},
                {16'h0ABA, 16'h0AB8, 16'h0ABE, 16'h0ABC}, 16'h0AB8, 64'h2002_1001_4004_3003};
    vecs[3] = '{16'hFFFE, 1, {16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001},
                {16'hFFFC, 16'hFFFA, 16'hFFF8, 16'hFFFE}, 16'hFFF8, 64'h0001_FFFF_7FFF_8000};
`else
    vecs[0] = '{16'h1234, 0, {16'hA3A3, 16'hA2A2, 16'hA1A1, 16'hA0A0},
                {16'h1236, 16'h1234, 16'h1232, 16'h1230}, 16'h1230, 64'hA3A3_A2A2_A1A1_A0A0};
    vecs[1] = '{16'h0044, 0, {16'h0004, 16'h0003, 16'h0002, 16'h0001},
                {16'h0046, 16'h0044, 16'h0042, 16'h0040}, 16'h0040, 64'h0004_0003_0002_0001};
    vecs[2] = '{16'h0ABC, 3, {16'h4004, 16'h3003, 16'h2002, 16'h1001},
                {16'h0ABE, 16'h0ABC, 16'h0ABA, 16'h0AB8}, 16'h0AB8, 64'h4004_3003_2002_1001};
    vecs[3] = '{16'hFFFE, 1, {16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001},
                {16'hFFFE, 16'hFFFC, 16'hFFFA, 16'hFFF8}, 16'hFFF8, 64'hFFFF_7FFF_8000_0001};
`endif

    bus.miss_req  = 1'b0;
    bus.miss_addr = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // reset state
    #2;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_line_valid", 64'(bus.line_valid), 64'd0);
    check("rst_line_addr", 64'(bus.line_addr), 64'd0);
    check("rst_line_data", bus.line_data, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      start_miss(vecs[v].miss_addr, 1'b0, 16'h0000);
      serve(vecs[v].waits, vecs[v].rdata, vecs[v].exp_addr, vecs[v].exp_line_addr, vecs[v].exp_data);
    end

    // stray acks in IDLE
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h5555;
      @(posedge clk);
      #1;
      check("stray_busy", 64'(bus.busy), 64'd0);
      check("stray_mem_rd", 64'(bus.mem_rd), 64'd0);
      check("stray_line_valid", 64'(bus.line_valid), 64'd0);
      check("stray_line_data", bus.line_data, vecs[3].exp_data);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;

    // miss_req held through the refill and the DONE cycle
    start_miss(16'h2000, 1'b1, 16'h3008);
    serve(0, {16'hB003, 16'hB002, 16'hB001, 16'hB000},
          {16'h2006, 16'h2004, 16'h2002, 16'h2000}, 16'h2000, 64'hB003_B002_B001_B000);
    @(posedge clk);
    #1;
    check("held_accept_busy", 64'(bus.busy), 64'd1);
    check("held_accept_mem_rd", 64'(bus.mem_rd), 64'd1);
    check("held_accept_addr", 64'(bus.mem_addr), 64'h3008);
    bus.miss_req = 1'b0;
    serve(0, {16'hD003, 16'hD002, 16'hD001, 16'hD000},
          {16'h300E, 16'h300C, 16'h300A, 16'h3008}, 16'h3008, 64'hD003_D002_D001_D000);

    // reset after the second word of a refill
    start_miss(16'h0100, 1'b0, 16'h0000);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h1111 * 16'(w + 1);
      @(posedge clk);
    end
    #1;
    check("abort_partial_data", bus.line_data, 64'hD003_D002_2222_1111);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_mem_rd", 64'(bus.mem_rd), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_line_data", bus.line_data, 64'd0);
    check("abort_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("abort_line_addr", 64'(bus.line_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_strobe", 64'(bus.line_valid), 64'd0);
    end
    start_miss(16'h0230, 1'b0, 16'h0000);
    serve(0, {16'hC003, 16'hC002, 16'hC001, 16'hC000},
          {16'h0236, 16'h0234, 16'h0232, 16'h0230}, 16'h0230, 64'hC003_C002_C001_C000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-side refill engine for the instruction cache. It accepts a miss address from the fetch stage and reads the four 16-bit words of the missing 8-byte line from instruction memory through a ready/ack handshake. It assembles them into one 64-bit line and presents line, line address and a one-cycle valid strobe to the cache write port. This block is the writer that fills the cache's tag/data array; the cache does the lookups.

## Interface
- ADDR_W, 16, byte-address width
- WORD_W, 16, memory word / instruction width
- LINE_WORDS, 4, words per cache line (fixed at 4; line = 64 bits)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- miss_req  in  1  fetch missed; level, sampled only in IDLE
- miss_addr  in  16  byte address of the missed instruction
- busy  out  1  refill in progress (any state other than IDLE)
- mem_rd  out  1  memory read request
- mem_addr  out  16  word-aligned byte address of the requested word
- mem_ack  in  1  memory returns mem_rdata this cycle
- mem_rdata  in  16  returned word
- line_valid  out  1  one-cycle strobe: line_data/line_addr are valid for a cache write
- line_addr  out  16  {miss_addr[15:3], 3'b000}
- line_data  out  64  assembled line; word k occupies bits [16k+15:16k]

## Operation
- States: IDLE, REQ, DONE.
- IDLE: if miss_req=1, latch line base = miss_addr[15:3], set word index = start index, go to REQ.
  - Start index is 0, or miss_addr[2:1] with the config macro defined.
- REQ: mem_rd=1, mem_addr={base, idx, 1'b0}.
  - On an edge with mem_rd & mem_ack, write mem_rdata into slot idx, increment idx mod 4, and count the word.
  - After the 4th word, go to DONE. mem_rd stays high between words.
- DONE: line_valid=1 for exactly one cycle, then go to IDLE.
- line_data and line_addr are registered and hold their value until the next refill writes them.
- mem_ack while mem_rd=0 is ignored.
- miss_req while busy=1 (REQ or DONE) is ignored. It is not queued; the fetch stage re-asserts it after line_valid.
- Index wrap: with start index 2, the fetch order is 2,3,0,1. Slot placement is always by idx, never by arrival order.
- Reset (any state, including mid-refill): state=IDLE, idx=0, word count=0, mem_rd=0, line_valid=0, busy=0, line_data=0, line_addr=0, mem_addr=0. An aborted line is never strobed.

## Timing
- Outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Accept at edge E0, where IDLE sees miss_req=1. mem_rd rises in the cycle after E0.
- Zero-wait memory (mem_ack=1 in every REQ cycle): words are captured at E1..E4, line_valid is high in the cycle after E4, busy drops the cycle after that.
- Miss-to-strobe latency is 5 cycles plus total memory wait cycles.
- Earliest next accept is the first cycle back in IDLE, so the minimum refill spacing is 6 cycles.
- mem_addr changes only on an ack edge. It is stable while mem_rd=1 and waiting.

## Configuration
- ICACHE_REFILL_CWF_EN defined: critical-word-first. The start index is miss_addr[2:1], wrapping mod 4, so the missed instruction is fetched first.
- ICACHE_REFILL_CWF_EN undefined: the start index is always 0, giving order 0,1,2,3.
- Cycle count, line_data layout and line_valid behaviour are identical in both builds.

## Structure
- Shared package icache_pkg holds ADDR_W, WORD_W, LINE_WORDS, LINE_W=64, the refill state encoding, and the line-address slicing constants (tag [15:6], index [5:3], word [2:1]). The cache uses the same constants.
- One sub-module: icache_line_buf.
  - Four 16-bit slot registers with a 2-bit write index and write enable.
  - Outputs the concatenated 64-bit line.
  - Async reset to 0.

## Test plan
- Zero-wait, CWF off, miss_addr=0x1234:
  - mem_addr sequence is 0x1230, 0x1232, 0x1234, 0x1236 with rdata A0,A1,A2,A3.
  - line_valid 5 cycles after accept; line_addr=0x1230; line_data=0xA3A2A1A0 (per 16-bit word).
- CWF on, miss_addr=0x0044:
  - Order is 0x0044, 0x0046, 0x0040, 0x0042; rdata 1,2,3,4.
  - line_data slots = {2,1,4,3} for words {3,2,1,0}.
- Wait states: mem_ack low for 3 cycles before each word.
  - mem_addr is held stable while waiting.
  - line_valid arrives at 5+12=17 cycles; data is correct.
- miss_req held high during a refill and in the DONE cycle:
  - Exactly one line_valid pulse.
  - The next accept is in the IDLE cycle; the second refill uses the new miss_addr.
- rst pulsed after the 2nd word:
  - mem_rd, busy and line_data drop to 0 immediately.
  - No line_valid.
  - A new miss after reset completes normally.
- Stray mem_ack=1 in IDLE: no state change, no capture.
